// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder
// Accepts a WIDTH-bit request vector over a valid/ready handshake, then emits
// the binary index of every set bit, one per beat, lowest-first or
// highest-first. A zero vector produces a single flagged beat.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   in_valid/in_ready       input handshake
//   in_vec   [WIDTH-1:0]    request vector, sampled only on accept
//   out_valid/out_ready     output beat handshake
//   out_idx  [IW-1:0]       index of the current set bit (0 for a zero vector)
//   out_last                final beat of the captured vector
//   out_zero                captured vector was all-zero
//   out_onehot              captured vector had exactly one bit set
//   out_count [IW:0]        popcount of the captured vector
module onehot_scan_encoder #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH)-1:0]   out_idx,
    output logic                       out_last,
    output logic                       out_zero,
    output logic                       out_onehot,
    output logic [$clog2(WIDTH):0]     out_count
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             zero_q, zero_d;
    logic             onehot_q, onehot_d;
    logic [IW:0]      count_q, count_d;

    logic [IW-1:0]    scan_idx;
    logic             single_bit;
    logic [IW:0]      in_pop;
    logic             beat;
    logic             accept;

    // Priority scan of the remaining bits. The loop direction is chosen so
    // that the final assignment wins: a descending loop leaves the lowest set
    // bit, an ascending loop leaves the highest.
    always_comb begin
        scan_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending_q[i]) begin
                    scan_idx = IW'(i);
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending_q[i]) begin
                    scan_idx = IW'(i);
                end
            end
        end
    end

    // Popcount of the incoming vector, captured alongside it on accept.
    always_comb begin
        in_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_pop = in_pop + {{IW{1'b0}}, in_vec[i]};
        end
    end

    // Exactly one bit left means this beat drains the vector.
    assign single_bit = (pending_q != '0) &&
                        ((pending_q & (pending_q - WIDTH'(1))) == '0);

    // out_last is qualified by out_valid so a stale zero flag left over from
    // the previous vector cannot show up while idle.
    assign out_valid  = (state_q == EMIT);
    assign out_idx    = scan_idx;
    assign out_last   = out_valid & (zero_q | single_bit);
    assign out_zero   = zero_q;
    assign out_onehot = onehot_q;
    assign out_count  = count_q;

    assign beat     = out_valid & out_ready;
    // Accepting on the last beat lets a new vector follow with no bubble;
    // rst_n gates the whole term so nothing is accepted during reset.
    assign in_ready = rst_n & ((state_q == IDLE) | (beat & out_last));
    assign accept   = in_valid & in_ready;

    // Next-state: clear the emitted bit on each beat, leave EMIT after the
    // last beat, and let a simultaneous accept override both.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = zero_q;
        onehot_d  = onehot_q;
        count_d   = count_q;

        if (beat) begin
            pending_d = pending_q & ~(WIDTH'(1) << scan_idx);
            if (out_last) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            state_d   = EMIT;
            pending_d = in_vec;
            count_d   = in_pop;
            onehot_d  = (in_pop == (IW + 1)'(1));
            zero_d    = (in_vec == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
            onehot_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
            onehot_q  <= onehot_d;
            count_q   <= count_d;
        end
    end

endmodule
